// File: rtl/drift_accumulator_array.sv
// Per-channel signed drift accumulators with saturation, threshold-offered
// corrections, edge-counted lockout after an accept, and quiet-edge decay.

package common_p;
  typedef struct packed {
    logic clk;
    logic sync_rst;
  } clk_dom_s;
endpackage

package clks_alot_p;
  localparam int unsigned DRIFT_COUNTER_WIDTH = 8;
endpackage

module drift_accumulator_array #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned ACC_WIDTH  = clks_alot_p::DRIFT_COUNTER_WIDTH,
  parameter int unsigned EDGE_WIDTH = 8
) (
  input  common_p::clk_dom_s                sys_dom_i,
  input  logic [CHANNELS-1:0]               accumulator_en_i,
  input  logic [CHANNELS-1:0]               pos_drift_detected_i,
  input  logic [CHANNELS-1:0]               neg_drift_detected_i,
  input  logic [CHANNELS-1:0]               any_valid_edge_i,
  input  logic [ACC_WIDTH-1:0]              max_drift_i,
  input  logic [ACC_WIDTH-1:0]              apply_threshold_i,
  input  logic [EDGE_WIDTH-1:0]             lockout_edges_i,
  input  logic [EDGE_WIDTH-1:0]             decay_edges_i,
  input  logic                              clear_flags_i,
  input  logic [CHANNELS-1:0]               drift_accepted_i,
  output logic [CHANNELS-1:0]               pos_drift_ready_o,
  output logic [CHANNELS-1:0]               neg_drift_ready_o,
  output logic [CHANNELS-1:0]               drift_acc_overflow_o,
  output logic [CHANNELS-1:0]               inverse_drift_violation_o,
  output logic [CHANNELS*(ACC_WIDTH+1)-1:0] drift_level_o
);

  localparam int unsigned LW = ACC_WIDTH + 1;  // stored accumulator width
  localparam int unsigned SW = ACC_WIDTH + 3;  // headroom for acc + d + k

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_POS  = 2'd1,
    DIR_NEG  = 2'd2
  } dir_e;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic signed [LW-1:0]  acc_q, acc_d;
    dir_e                  dir_q, dir_d;
    logic [EDGE_WIDTH-1:0] lock_q, lock_d;
    logic [EDGE_WIDTH-1:0] quiet_q, quiet_d;
    logic                  ovf_q, ovf_d;
    logic                  viol_q, viol_d;
    logic                  pos_rdy_c, neg_rdy_c;

    logic signed [SW-1:0]  acc_x, thr_x, max_x, one_x, step_x, sum_x, acc_n;
    logic [EDGE_WIDTH-1:0] quiet_inc;
    logic                  d_pos, d_neg, lock_z, accept, decay;
    logic                  set_ovf, set_viol;
    dir_e                  d_dir;

    // Readiness, accumulation with saturation, direction tracking, counters and flags
    always_comb begin
      acc_d     = acc_q;
      dir_d     = dir_q;
      lock_d    = lock_q;
      quiet_d   = quiet_q;
      ovf_d     = ovf_q;
      viol_d    = viol_q;
      set_ovf   = 1'b0;
      set_viol  = 1'b0;
      one_x     = SW'(1);
      step_x    = '0;
      acc_x     = {{2{acc_q[LW-1]}}, acc_q};
      thr_x     = {2'b00, 1'b0, apply_threshold_i};
      max_x     = {2'b00, 1'b0, max_drift_i};

      // Simultaneous pos and neg cancel
      d_pos     = pos_drift_detected_i[c] & ~neg_drift_detected_i[c];
      d_neg     = neg_drift_detected_i[c] & ~pos_drift_detected_i[c];
      d_dir     = d_pos ? DIR_POS : DIR_NEG;
      lock_z    = (lock_q == '0);

      pos_rdy_c = !sys_dom_i.sync_rst && accumulator_en_i[c] && lock_z &&
                  (apply_threshold_i != '0) && (acc_x >= thr_x);
      neg_rdy_c = !sys_dom_i.sync_rst && accumulator_en_i[c] && lock_z &&
                  (apply_threshold_i != '0) && (acc_x <= -thr_x);
      accept    = drift_accepted_i[c] && (pos_rdy_c || neg_rdy_c);

      quiet_inc = (&quiet_q) ? quiet_q : quiet_q + EDGE_WIDTH'(1);
      decay     = any_valid_edge_i[c] && (decay_edges_i != '0) &&
                  (quiet_inc >= decay_edges_i) && (acc_q != '0) &&
                  !d_pos && !d_neg && !accept;

      if (d_pos) step_x = step_x + one_x;
      if (d_neg) step_x = step_x - one_x;
      if (accept) step_x = pos_rdy_c ? (step_x - thr_x) : (step_x + thr_x);
      if (decay) step_x = acc_x[SW-1] ? (step_x + one_x) : (step_x - one_x);
      sum_x = acc_x + step_x;

      // Clamp to the current limit; only a detection pushing outward flags overflow
      acc_n = sum_x;
      if (sum_x > max_x) begin
        acc_n   = max_x;
        set_ovf = d_pos;
      end else if (sum_x < -max_x) begin
        acc_n   = -max_x;
        set_ovf = d_neg;
      end
      acc_d = acc_n[LW-1:0];

      if (d_pos || d_neg) begin
        if (dir_q == DIR_NONE || dir_q == d_dir || lock_z) dir_d = d_dir;
        else set_viol = 1'b1;
      end
      // A reversal during lockout keeps the held direction even if acc lands on 0
      if (!set_viol && acc_n == '0) dir_d = DIR_NONE;

      if (accept) lock_d = lockout_edges_i;
      else if (any_valid_edge_i[c] && !lock_z) lock_d = lock_q - EDGE_WIDTH'(1);

      if (d_pos || d_neg || accept || decay) quiet_d = '0;
      else if (any_valid_edge_i[c]) quiet_d = quiet_inc;

      ovf_d  = set_ovf  | (ovf_q  & ~clear_flags_i);
      viol_d = set_viol | (viol_q & ~clear_flags_i);

      // Disabled channel is parked at zero and ignores everything, flags included
      if (!accumulator_en_i[c]) begin
        acc_d   = '0;
        dir_d   = DIR_NONE;
        lock_d  = '0;
        quiet_d = '0;
        ovf_d   = ovf_q;
        viol_d  = viol_q;
      end
    end

    // Channel state register with synchronous reset
    always_ff @(posedge sys_dom_i.clk) begin
      if (sys_dom_i.sync_rst) begin
        acc_q   <= '0;
        dir_q   <= DIR_NONE;
        lock_q  <= '0;
        quiet_q <= '0;
        ovf_q   <= 1'b0;
        viol_q  <= 1'b0;
      end else begin
        acc_q   <= acc_d;
        dir_q   <= dir_d;
        lock_q  <= lock_d;
        quiet_q <= quiet_d;
        ovf_q   <= ovf_d;
        viol_q  <= viol_d;
      end
    end

    assign pos_drift_ready_o[c]         = pos_rdy_c;
    assign neg_drift_ready_o[c]         = neg_rdy_c;
    assign drift_acc_overflow_o[c]      = ovf_q;
    assign inverse_drift_violation_o[c] = viol_q;
    assign drift_level_o[c*LW +: LW]    = acc_q;
  end

endmodule

// File: tb/tb_drift_accumulator_array.sv
// Bench for drift_accumulator_array: directed scenarios then random traffic,
// all checked against an integer reference model of each channel.

module tb_drift_accumulator_array;

  localparam int CH = 4;
  localparam int AW = 8;
  localparam int EW = 8;
  localparam int LW = AW + 1;

  logic clk = 1'b0;
  logic rst;
  common_p::clk_dom_s sys_dom;
  assign sys_dom.clk      = clk;
  assign sys_dom.sync_rst = rst;

  logic [CH-1:0]    en, pos, neg, edg, acc_in;
  logic [AW-1:0]    max_v, thr;
  logic [EW-1:0]    le, de;
  logic             clr;
  logic [CH-1:0]    pos_rdy, neg_rdy, ovf, viol;
  logic [CH*LW-1:0] level;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int m_acc[CH], m_dir[CH], m_lock[CH], m_quiet[CH];
  bit m_ovf[CH], m_viol[CH];

  drift_accumulator_array #(.CHANNELS(CH), .ACC_WIDTH(AW), .EDGE_WIDTH(EW)) dut (
    .sys_dom_i                 (sys_dom),
    .accumulator_en_i          (en),
    .pos_drift_detected_i      (pos),
    .neg_drift_detected_i      (neg),
    .any_valid_edge_i          (edg),
    .max_drift_i               (max_v),
    .apply_threshold_i         (thr),
    .lockout_edges_i           (le),
    .decay_edges_i             (de),
    .clear_flags_i             (clr),
    .drift_accepted_i          (acc_in),
    .pos_drift_ready_o         (pos_rdy),
    .neg_drift_ready_o         (neg_rdy),
    .drift_acc_overflow_o      (ovf),
    .inverse_drift_violation_o (viol),
    .drift_level_o             (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_prdy(int c);
    return !rst && en[c] && m_lock[c] == 0 && thr != 0 && m_acc[c] >= int'(thr);
  endfunction

  function automatic bit m_nrdy(int c);
    return !rst && en[c] && m_lock[c] == 0 && thr != 0 && m_acc[c] <= -int'(thr);
  endfunction

  // One clock of the behavioural model using the currently applied inputs
  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      if (rst) begin
        m_acc[c] = 0; m_dir[c] = 0; m_lock[c] = 0; m_quiet[c] = 0;
        m_ovf[c] = 0; m_viol[c] = 0;
      end else if (!en[c]) begin
        m_acc[c] = 0; m_dir[c] = 0; m_lock[c] = 0; m_quiet[c] = 0;
      end else begin
        int d, k, qn, t, nd, mx;
        bit pr, nr, ta, dec, so, sv;
        mx = int'(max_v);
        d  = int'(pos[c]) - int'(neg[c]);
        pr = m_prdy(c);
        nr = m_nrdy(c);
        ta = acc_in[c] && (pr || nr);
        k  = !ta ? 0 : (pr ? -int'(thr) : int'(thr));
        qn = (m_quiet[c] < 255) ? m_quiet[c] + 1 : 255;
        dec = edg[c] && de != 0 && qn >= int'(de) && m_acc[c] != 0 && d == 0 && !ta;
        t  = m_acc[c] + d + k + (dec ? (m_acc[c] > 0 ? -1 : 1) : 0);
        so = (d > 0 && t > mx) || (d < 0 && t < -mx);
        if (t > mx) t = mx;
        if (t < -mx) t = -mx;
        sv = 0;
        nd = m_dir[c];
        if (d != 0) begin
          if (m_dir[c] == 0 || m_dir[c] == d || m_lock[c] == 0) nd = d;
          else sv = 1;
        end
        if (!sv && t == 0) nd = 0;
        if (ta) m_lock[c] = int'(le);
        else if (edg[c] && m_lock[c] > 0) m_lock[c] = m_lock[c] - 1;
        if (d != 0 || ta || dec) m_quiet[c] = 0;
        else if (edg[c]) m_quiet[c] = qn;
        m_acc[c]  = t;
        m_dir[c]  = nd;
        m_ovf[c]  = so || (m_ovf[c] && !clr);
        m_viol[c] = sv || (m_viol[c] && !clr);
      end
    end
  endtask

  // Apply current inputs for one clock; check readies before and state after the edge
  task automatic cyc(input string tag);
    logic [CH-1:0] ep, en_, eo, ev;
    #1;
    for (int c = 0; c < CH; c++) begin
      ep[c]  = m_prdy(c);
      en_[c] = m_nrdy(c);
    end
    chk({tag, ".pos_rdy"}, 64'(pos_rdy), 64'(ep));
    chk({tag, ".neg_rdy"}, 64'(neg_rdy), 64'(en_));
    model_step();
    @(posedge clk);
    #1;
    for (int c = 0; c < CH; c++) begin
      logic [LW-1:0] ea;
      ea = LW'(m_acc[c]);
      chk($sformatf("%s.level%0d", tag, c), 64'(level[c*LW +: LW]), 64'(ea));
      eo[c] = m_ovf[c];
      ev[c] = m_viol[c];
    end
    chk({tag, ".ovf"}, 64'(ovf), 64'(eo));
    chk({tag, ".viol"}, 64'(viol), 64'(ev));
    pos = '0; neg = '0; edg = '0; acc_in = '0; clr = 1'b0;
  endtask

  function automatic logic [LW-1:0] lvl(int c);
    return level[c*LW +: LW];
  endfunction

  initial begin
    rst = 1'b1; en = '1; pos = '0; neg = '0; edg = '0; acc_in = '0; clr = 1'b0;
    max_v = 8'd3; thr = 8'd0; le = 8'd4; de = 8'd0;
    for (int c = 0; c < CH; c++) begin
      m_acc[c] = 0; m_dir[c] = 0; m_lock[c] = 0; m_quiet[c] = 0;
      m_ovf[c] = 0; m_viol[c] = 0;
    end
    @(posedge clk);
    #1;
    cyc("reset");
    chk("reset.level_all", 64'(level), 64'd0);
    rst = 1'b0;

    // Saturation at max=3 with no threshold
    for (int i = 1; i <= 5; i++) begin
      pos[0] = 1'b1;
      cyc($sformatf("sat%0d", i));
      if (i == 3) chk("sat.no_ovf_yet", 64'(ovf[0]), 64'd0);
      if (i == 4) chk("sat.ovf_on_4th", 64'(ovf[0]), 64'd1);
    end
    chk("sat.acc3", 64'(lvl(0)), 64'd3);

    // Fresh channel via enable drop, then clear flags
    en[0] = 1'b0; cyc("dis");
    chk("dis.flag_held", 64'(ovf[0]), 64'd1);
    en[0] = 1'b1; clr = 1'b1; cyc("clr0");

    // Threshold, accept and lockout
    max_v = 8'd10; thr = 8'd2; le = 8'd4;
    pos[0] = 1'b1; cyc("thr1");
    pos[0] = 1'b1; cyc("thr2");
    #1 chk("thr.pos_ready", 64'(pos_rdy[0]), 64'd1);
    acc_in[0] = 1'b1; cyc("accept");
    chk("accept.acc0", 64'(lvl(0)), 64'd0);
    pos[0] = 1'b1; cyc("relock1");
    pos[0] = 1'b1; cyc("relock2");
    for (int i = 1; i <= 4; i++) begin
      edg[0] = 1'b1; cyc($sformatf("lock_edge%0d", i));
    end
    #1 chk("lock.ready_after4", 64'(pos_rdy[0]), 64'd1);

    // Cancel, then accept together with a pos pulse
    pos[0] = 1'b1; neg[0] = 1'b1; cyc("cancel");
    chk("cancel.acc2", 64'(lvl(0)), 64'd2);
    acc_in[0] = 1'b1; pos[0] = 1'b1; cyc("acc_det");
    chk("acc_det.acc1", 64'(lvl(0)), 64'd1);

    // Reversal during lockout
    neg[0] = 1'b1; cyc("viol");
    chk("viol.flag", 64'(viol[0]), 64'd1);
    chk("viol.acc0", 64'(lvl(0)), 64'd0);
    clr = 1'b1; cyc("viol_clr");
    chk("viol_clr.flag", 64'(viol[0]), 64'd0);

    // Decay
    for (int i = 0; i < 4; i++) begin
      edg[0] = 1'b1; cyc("unlock");
    end
    thr = 8'd0;
    neg[0] = 1'b1; cyc("dneg1");
    neg[0] = 1'b1; cyc("dneg2");
    de = 8'd3;
    for (int i = 1; i <= 6; i++) begin
      edg[0] = 1'b1; cyc($sformatf("decay_e%0d", i));
      if (i == 3) chk("decay.e3", 64'(lvl(0)), 64'h1FF);
      if (i == 6) chk("decay.e6", 64'(lvl(0)), 64'd0);
    end
    neg[0] = 1'b1; cyc("dneg3");
    neg[0] = 1'b1; cyc("dneg4");
    edg[0] = 1'b1; cyc("restart_e1");
    edg[0] = 1'b1; pos[0] = 1'b1; cyc("restart_e2");
    edg[0] = 1'b1; cyc("restart_e3");
    chk("restart.e3_no_decay", 64'(lvl(0)), 64'h1FF);
    edg[0] = 1'b1; cyc("restart_e4");
    edg[0] = 1'b1; cyc("restart_e5");
    chk("restart.e5_decay", 64'(lvl(0)), 64'd0);

    // Reset in the middle of a lockout
    de = 8'd0; thr = 8'd5; le = 8'd2;
    for (int i = 0; i < 5; i++) begin
      pos[0] = 1'b1; cyc("r_up");
    end
    acc_in[0] = 1'b1; cyc("r_acc");
    for (int i = 0; i < 5; i++) begin
      pos[0] = 1'b1; cyc("r_up2");
    end
    chk("r.acc5", 64'(lvl(0)), 64'd5);
    rst = 1'b1; acc_in[0] = 1'b1; cyc("rst_mid");
    chk("rst_mid.level", 64'(level), 64'd0);
    chk("rst_mid.ready", 64'({pos_rdy, neg_rdy}), 64'd0);
    rst = 1'b0;

    // Enable drop on one channel only
    max_v = 8'd1; thr = 8'd0;
    pos[0] = 1'b1; pos[1] = 1'b1; cyc("en1");
    pos[1] = 1'b1; cyc("en2");
    en[1] = 1'b0; cyc("en_drop");
    chk("en_drop.acc1", 64'(lvl(1)), 64'd0);
    chk("en_drop.flag1", 64'(ovf[1]), 64'd1);
    chk("en_drop.acc0", 64'(lvl(0)), 64'd1);
    en[1] = 1'b1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if (i % 32 == 0) begin
        max_v = AW'($urandom_range(0, 12));
        thr   = AW'($urandom_range(0, 4));
        le    = EW'($urandom_range(0, 5));
        de    = EW'($urandom_range(0, 4));
      end
      rst    = ($urandom_range(0, 99) == 0);
      en     = ~CH'($urandom & $urandom & $urandom);
      pos    = CH'($urandom);
      neg    = CH'($urandom & $urandom);
      edg    = CH'($urandom);
      acc_in = CH'($urandom);
      clr    = ($urandom_range(0, 15) == 0);
      cyc($sformatf("rnd%0d", i));
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
